// File: rtl/csr_exec_pipe_if.sv
// ---------------------------------------------------------------------------
// csr_exec_pipe_if
// Bundles the decode-side CSR instruction fields, the CSR register file
// read/write ports and the EX-stage results of csr_exec_pipe.
//   master : decode stage + CSR register file (drives instruction fields and
//            csr_rdata, consumes read address, rd value and write port)
//   slave  : csr_exec_pipe
// ---------------------------------------------------------------------------
interface csr_exec_pipe_if;
  logic        id_csr_valid;
  logic [1:0]  id_csr_op;
  logic        id_csr_imm;
  logic [11:0] id_csr_addr;
  logic [4:0]  id_rs1_idx;
  logic [31:0] id_rs1_data;
  logic [31:0] csr_rdata;
  logic [11:0] csr_raddr;
  logic [31:0] ex_rd_value;
  logic        ex_valid;
  logic        MEM_WB_CSR_write;
  logic [11:0] MEM_WB_CSR_addr;
  logic [31:0] WB_CSR_res;
  logic        illegal;

  modport master (
    output id_csr_valid, id_csr_op, id_csr_imm, id_csr_addr,
    output id_rs1_idx, id_rs1_data, csr_rdata,
    input  csr_raddr, ex_rd_value, ex_valid,
    input  MEM_WB_CSR_write, MEM_WB_CSR_addr, WB_CSR_res, illegal
  );

  modport slave (
    input  id_csr_valid, id_csr_op, id_csr_imm, id_csr_addr,
    input  id_rs1_idx, id_rs1_data, csr_rdata,
    output csr_raddr, ex_rd_value, ex_valid,
    output MEM_WB_CSR_write, MEM_WB_CSR_addr, WB_CSR_res, illegal
  );
endinterface

// File: rtl/csr_exec_pipe.sv
// ---------------------------------------------------------------------------
// csr_exec_pipe
// Pipelined CSRRW/CSRRS/CSRRC execute and write-back unit feeding the CSR
// register file. Reads the old CSR value in EX (with forwarding from the
// EX/MEM and MEM/WB stages), returns it for rd, computes the new value and
// carries the write through EX/MEM and MEM/WB to the file's write port.
// Ports:
//   clk, rst : core clock, synchronous active-high reset
//   stall    : hold ID/EX and EX/MEM, bubble into MEM/WB
//   flush    : bubble into ID/EX
//   bus      : decode fields, CSR file read/write port, EX results
// Parameter:
//   RO_CHECK : suppress and flag writes to addr[11:10]==2'b11
// ---------------------------------------------------------------------------
module csr_exec_pipe #(
  parameter bit RO_CHECK = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           stall,
  input  logic           flush,
  csr_exec_pipe_if.slave bus
);

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  function automatic logic [31:0] f_csr_new(input logic [1:0]  op,
                                            input logic [31:0] old,
                                            input logic [31:0] src);
    case (op)
      OP_RW:   f_csr_new = src;
      OP_RS:   f_csr_new = old | src;
      OP_RC:   f_csr_new = old & ~src;
      default: f_csr_new = old;
    endcase
  endfunction

  // ID/EX
  logic        r_vld_p0;
  logic [1:0]  r_op_p0;
  logic [11:0] r_addr_p0;
  logic [31:0] r_src_p0;
  logic        r_wri_p0;
  logic        r_ill_seen_p0;
  // EX/MEM
  logic        r_vld_p1;
  logic        r_we_p1;
  logic [11:0] r_addr_p1;
  logic [31:0] r_new_p1;
  // MEM/WB
  logic        r_we_p2;
  logic [11:0] r_addr_p2;
  logic [31:0] r_new_p2;

  logic        w_id_vld;
  logic [31:0] w_id_src;
  logic        w_id_wri;
  logic        w_ro_addr;
  logic [31:0] w_old;
  logic [31:0] w_new;
  logic        w_we_ex;
  logic        w_ill_ex;

  // ---- decode side: operand select and write intent ----
  assign w_id_vld = bus.id_csr_valid & (bus.id_csr_op != 2'b00);
  assign w_id_src = bus.id_csr_imm ? {27'b0, bus.id_rs1_idx} : bus.id_rs1_data;
  // RS/RC only write when the source operand field is nonzero; for both the
  // register and immediate forms that field is rs1_idx.
  assign w_id_wri = (bus.id_csr_op == OP_RW) | (bus.id_rs1_idx != 5'd0);

  // ---- EX: old value with forwarding, new value, write enable ----
  assign w_ro_addr = RO_CHECK && (r_addr_p0[11:10] == 2'b11);

  always_comb begin
    w_old = bus.csr_rdata;
    if (r_vld_p1 && r_we_p1 && (r_addr_p1 == r_addr_p0))
      w_old = r_new_p1;
    else if (r_we_p2 && (r_addr_p2 == r_addr_p0))
      w_old = r_new_p2;
  end

  assign w_new    = f_csr_new(r_op_p0, w_old, r_src_p0);
  assign w_we_ex  = r_vld_p0 & r_wri_p0 & ~w_ro_addr;
  assign w_ill_ex = r_vld_p0 & r_wri_p0 & w_ro_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p0      <= 1'b0;
      r_op_p0       <= 2'b00;
      r_addr_p0     <= 12'd0;
      r_src_p0      <= 32'd0;
      r_wri_p0      <= 1'b0;
      r_ill_seen_p0 <= 1'b0;
      r_vld_p1      <= 1'b0;
      r_we_p1       <= 1'b0;
      r_addr_p1     <= 12'd0;
      r_new_p1      <= 32'd0;
      r_we_p2       <= 1'b0;
      r_addr_p2     <= 12'd0;
      r_new_p2      <= 32'd0;
    end else begin
      // ---- ID -> ID/EX ----
      if (!stall) begin
        r_vld_p0  <= w_id_vld;
        r_op_p0   <= bus.id_csr_op;
        r_addr_p0 <= bus.id_csr_addr;
        r_src_p0  <= w_id_src;
        r_wri_p0  <= w_id_wri;
      end
      if (flush)
        r_vld_p0 <= 1'b0;

      // Remembers that the held EX instruction already raised illegal, so a
      // stall does not stretch the pulse. Cleared whenever ID/EX reloads.
      if (flush || !stall)
        r_ill_seen_p0 <= 1'b0;
      else if (w_ill_ex)
        r_ill_seen_p0 <= 1'b1;

      // ---- EX -> EX/MEM ----
      if (!stall) begin
        r_vld_p1  <= r_vld_p0;
        r_we_p1   <= w_we_ex;
        r_addr_p1 <= r_addr_p0;
        r_new_p1  <= w_new;
      end

      // ---- EX/MEM -> MEM/WB ----
      if (stall) begin
        r_we_p2 <= 1'b0;
      end else begin
        r_we_p2   <= r_we_p1;
        r_addr_p2 <= r_addr_p1;
        r_new_p2  <= r_new_p1;
      end
    end
  end

  assign bus.csr_raddr        = r_addr_p0;
  assign bus.ex_rd_value      = w_old;
  assign bus.ex_valid         = r_vld_p0;
  assign bus.illegal          = w_ill_ex & ~r_ill_seen_p0;
  assign bus.MEM_WB_CSR_write = r_we_p2;
  assign bus.MEM_WB_CSR_addr  = r_addr_p2;
  assign bus.WB_CSR_res       = r_new_p2;

endmodule

// File: tb/tb_csr_exec_pipe.sv
// Directed bench for csr_exec_pipe with a simple CSR register file model.
module tb_csr_exec_pipe;
  logic clk = 1'b0;
  logic rst;
  logic stall;
  logic flush;

  csr_exec_pipe_if bus();

  csr_exec_pipe #(.RO_CHECK(1'b1)) dut (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // CSR register file environment: combinational read, commit on posedge,
  // plus a backdoor preload port and a log of every committed write.
  logic [31:0] csr_mem [0:4095];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = 12'd0;
  logic [31:0] pl_data = 32'd0;
  logic [11:0] wr_a_q[$];
  logic [31:0] wr_d_q[$];

  assign bus.csr_rdata = csr_mem[bus.csr_raddr];

  always @(posedge clk) begin
    if (pl_en) csr_mem[pl_addr] <= pl_data;
    else if (bus.MEM_WB_CSR_write) csr_mem[bus.MEM_WB_CSR_addr] <= bus.WB_CSR_res;
    if (bus.MEM_WB_CSR_write) begin
      wr_a_q.push_back(bus.MEM_WB_CSR_addr);
      wr_d_q.push_back(bus.WB_CSR_res);
    end
  end

  int n_pass = 0;
  int n_total = 0;

  localparam logic [1:0] RW = 2'b01, RS = 2'b10, RC = 2'b11;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic imm, input logic [11:0] addr,
                       input logic [4:0] idx, input logic [31:0] data);
    bus.id_csr_valid = 1'b1;
    bus.id_csr_op    = op;
    bus.id_csr_imm   = imm;
    bus.id_csr_addr  = addr;
    bus.id_rs1_idx   = idx;
    bus.id_rs1_data  = data;
  endtask

  task automatic idle();
    bus.id_csr_valid = 1'b0;
    bus.id_csr_op    = 2'b00;
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic drain();
    idle();
    repeat (4) tick();
    wr_a_q.delete();
    wr_d_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    idle();
    bus.id_csr_imm = 1'b0; bus.id_csr_addr = 12'd0;
    bus.id_rs1_idx = 5'd0; bus.id_rs1_data = 32'd0;
    preload(12'h000, 32'hA5A50000);
    tick();
    n_total++; if (bus.csr_raddr !== 12'd0) $display("FAIL rst_raddr got %h want 000", bus.csr_raddr); else n_pass++;
    n_total++; if (bus.ex_valid !== 1'b0) $display("FAIL rst_ex_valid got %b want 0", bus.ex_valid); else n_pass++;
    n_total++; if (bus.MEM_WB_CSR_write !== 1'b0) $display("FAIL rst_write got %b want 0", bus.MEM_WB_CSR_write); else n_pass++;
    n_total++; if (bus.MEM_WB_CSR_addr !== 12'd0) $display("FAIL rst_waddr got %h want 000", bus.MEM_WB_CSR_addr); else n_pass++;
    n_total++; if (bus.WB_CSR_res !== 32'd0) $display("FAIL rst_wdata got %h want 0", bus.WB_CSR_res); else n_pass++;
    n_total++; if (bus.illegal !== 1'b0) $display("FAIL rst_illegal got %b want 0", bus.illegal); else n_pass++;
    n_total++; if (bus.ex_rd_value !== 32'hA5A50000) $display("FAIL rst_rd_value got %h want a5a50000", bus.ex_rd_value); else n_pass++;
    rst = 1'b0;
    drain();
  endtask

  task automatic test_basic_write();
    preload(12'h340, 32'h11111111);
    drive(RW, 1'b0, 12'h340, 5'd1, 32'hDEADBEEF);
    tick();
    idle();
    n_total++; if (bus.ex_valid !== 1'b1) $display("FAIL basic_ex_valid got %b want 1", bus.ex_valid); else n_pass++;
    n_total++; if (bus.ex_rd_value !== 32'h11111111) $display("FAIL basic_rd got %h want 11111111", bus.ex_rd_value); else n_pass++;
    tick();
    n_total++; if (bus.MEM_WB_CSR_write !== 1'b0) $display("FAIL basic_early_write got %b want 0", bus.MEM_WB_CSR_write); else n_pass++;
    tick();
    n_total++; if (bus.MEM_WB_CSR_write !== 1'b1) $display("FAIL basic_write got %b want 1", bus.MEM_WB_CSR_write); else n_pass++;
    n_total++; if (bus.MEM_WB_CSR_addr !== 12'h340) $display("FAIL basic_waddr got %h want 340", bus.MEM_WB_CSR_addr); else n_pass++;
    n_total++; if (bus.WB_CSR_res !== 32'hDEADBEEF) $display("FAIL basic_wdata got %h want deadbeef", bus.WB_CSR_res); else n_pass++;
    tick();
    n_total++; if (bus.MEM_WB_CSR_write !== 1'b0) $display("FAIL basic_write_end got %b want 0", bus.MEM_WB_CSR_write); else n_pass++;
    drain();
  endtask

  task automatic test_forwarding();
    preload(12'h300, 32'h12345678);
    drive(RW, 1'b0, 12'h300, 5'd1, 32'h000000F0);
    tick();
    n_total++; if (bus.ex_rd_value !== 32'h12345678) $display("FAIL fwd_rw_rd got %h want 12345678", bus.ex_rd_value); else n_pass++;
    drive(RS, 1'b0, 12'h300, 5'd2, 32'h0000000F);
    tick();
    n_total++; if (bus.ex_rd_value !== 32'h000000F0) $display("FAIL fwd_rs_rd got %h want f0", bus.ex_rd_value); else n_pass++;
    drive(RC, 1'b0, 12'h300, 5'd3, 32'h000000FF);
    tick();
    idle();
    n_total++; if (bus.ex_rd_value !== 32'h000000FF) $display("FAIL fwd_rc_rd got %h want ff", bus.ex_rd_value); else n_pass++;
    n_total++; if (bus.MEM_WB_CSR_write !== 1'b1 || bus.WB_CSR_res !== 32'h000000F0)
      $display("FAIL fwd_w0 got we=%b d=%h want we=1 d=f0", bus.MEM_WB_CSR_write, bus.WB_CSR_res); else n_pass++;
    tick();
    n_total++; if (bus.MEM_WB_CSR_write !== 1'b1 || bus.WB_CSR_res !== 32'h000000FF)
      $display("FAIL fwd_w1 got we=%b d=%h want we=1 d=ff", bus.MEM_WB_CSR_write, bus.WB_CSR_res); else n_pass++;
    tick();
    n_total++; if (bus.MEM_WB_CSR_write !== 1'b1 || bus.WB_CSR_res !== 32'h00000000 || bus.MEM_WB_CSR_addr !== 12'h300)
      $display("FAIL fwd_w2 got we=%b a=%h d=%h want we=1 a=300 d=0", bus.MEM_WB_CSR_write, bus.MEM_WB_CSR_addr, bus.WB_CSR_res); else n_pass++;
    drain();
    // distance-2: the only in-flight source is MEM/WB
    preload(12'h301, 32'h00000000);
    drive(RW, 1'b0, 12'h301, 5'd1, 32'h000000AA);
    tick();
    idle();
    tick();
    drive(RS, 1'b0, 12'h301, 5'd2, 32'h00000005);
    tick();
    idle();
    n_total++; if (bus.ex_rd_value !== 32'h000000AA) $display("FAIL fwd_d2_rd got %h want aa", bus.ex_rd_value); else n_pass++;
    tick();
    tick();
    n_total++; if (bus.MEM_WB_CSR_write !== 1'b1 || bus.WB_CSR_res !== 32'h000000AF)
      $display("FAIL fwd_d2_w got we=%b d=%h want we=1 d=af", bus.MEM_WB_CSR_write, bus.WB_CSR_res); else n_pass++;
    drain();
  endtask

  task automatic test_suppression();
    preload(12'h305, 32'h0BADF00D);
    drive(RS, 1'b0, 12'h305, 5'd0, 32'hFFFFFFFF);
    tick();
    n_total++; if (bus.ex_rd_value !== 32'h0BADF00D) $display("FAIL sup_rs_rd got %h want 0badf00d", bus.ex_rd_value); else n_pass++;
    drive(RC, 1'b1, 12'h305, 5'd0, 32'hFFFFFFFF);
    tick();
    idle();
    n_total++; if (bus.ex_rd_value !== 32'h0BADF00D) $display("FAIL sup_rci_rd got %h want 0badf00d", bus.ex_rd_value); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if (bus.MEM_WB_CSR_write !== 1'b0) $display("FAIL sup_write[%0d] got %b want 0", i, bus.MEM_WB_CSR_write); else n_pass++;
    end
    drain();
  endtask

  task automatic test_readonly();
    preload(12'hC00, 32'h00000777);
    preload(12'hC01, 32'h00000000);
    drive(RW, 1'b0, 12'hC00, 5'd1, 32'h00000005);
    tick();
    idle();
    n_total++; if (bus.illegal !== 1'b1) $display("FAIL ro_illegal got %b want 1", bus.illegal); else n_pass++;
    tick();
    n_total++; if (bus.illegal !== 1'b0) $display("FAIL ro_illegal_end got %b want 0", bus.illegal); else n_pass++;
    repeat (3) tick();
    n_total++; if (wr_a_q.size() !== 0) $display("FAIL ro_no_write got %0d writes want 0", wr_a_q.size()); else n_pass++;
    drive(RS, 1'b0, 12'hC00, 5'd0, 32'h00000000);
    tick();
    idle();
    n_total++; if (bus.illegal !== 1'b0) $display("FAIL ro_read_illegal got %b want 0", bus.illegal); else n_pass++;
    n_total++; if (bus.ex_rd_value !== 32'h00000777) $display("FAIL ro_read_rd got %h want 777", bus.ex_rd_value); else n_pass++;
    drain();
    drive(RW, 1'b0, 12'hC01, 5'd1, 32'h00000005);
    tick();
    idle();
    n_total++; if (bus.illegal !== 1'b1) $display("FAIL ro_stall_first got %b want 1", bus.illegal); else n_pass++;
    stall = 1'b1;
    tick();
    n_total++; if (bus.ex_valid !== 1'b1 || bus.illegal !== 1'b0)
      $display("FAIL ro_stall_repeat got v=%b ill=%b want v=1 ill=0", bus.ex_valid, bus.illegal); else n_pass++;
    stall = 1'b0;
    tick();
    repeat (3) tick();
    n_total++; if (wr_a_q.size() !== 0) $display("FAIL ro_stall_no_write got %0d writes want 0", wr_a_q.size()); else n_pass++;
    drain();
  endtask

  task automatic test_stall();
    int cnt;
    preload(12'h341, 32'h00000000);
    drive(RW, 1'b0, 12'h341, 5'd1, 32'h12345678);
    tick();
    drive(RS, 1'b0, 12'h341, 5'd2, 32'h80000000);
    tick();
    idle();
    n_total++; if (bus.ex_rd_value !== 32'h12345678) $display("FAIL stall_fwd_rd got %h want 12345678", bus.ex_rd_value); else n_pass++;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if (bus.MEM_WB_CSR_write !== 1'b0 || bus.ex_valid !== 1'b1 || bus.ex_rd_value !== 32'h12345678)
        $display("FAIL stall_hold[%0d] got we=%b v=%b rd=%h want we=0 v=1 rd=12345678",
                 i, bus.MEM_WB_CSR_write, bus.ex_valid, bus.ex_rd_value); else n_pass++;
    end
    stall = 1'b0;
    tick();
    n_total++; if (bus.MEM_WB_CSR_write !== 1'b1 || bus.WB_CSR_res !== 32'h12345678 || bus.MEM_WB_CSR_addr !== 12'h341)
      $display("FAIL stall_w0 got we=%b a=%h d=%h want we=1 a=341 d=12345678", bus.MEM_WB_CSR_write, bus.MEM_WB_CSR_addr, bus.WB_CSR_res); else n_pass++;
    tick();
    n_total++; if (bus.MEM_WB_CSR_write !== 1'b1 || bus.WB_CSR_res !== 32'h92345678)
      $display("FAIL stall_w1 got we=%b d=%h want we=1 d=92345678", bus.MEM_WB_CSR_write, bus.WB_CSR_res); else n_pass++;
    tick();
    n_total++; if (bus.MEM_WB_CSR_write !== 1'b0) $display("FAIL stall_w_end got %b want 0", bus.MEM_WB_CSR_write); else n_pass++;
    cnt = 0;
    foreach (wr_d_q[i]) if (wr_d_q[i] === 32'h12345678) cnt++;
    n_total++; if (cnt !== 1) $display("FAIL stall_once got %0d writes want 1", cnt); else n_pass++;
    drain();
  endtask

  task automatic test_flush();
    drive(RW, 1'b0, 12'h342, 5'd1, 32'h00000055);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    n_total++; if (bus.ex_valid !== 1'b0) $display("FAIL flush_ex_valid got %b want 0", bus.ex_valid); else n_pass++;
    repeat (3) tick();
    n_total++; if (wr_a_q.size() !== 0) $display("FAIL flush_no_write got %0d writes want 0", wr_a_q.size()); else n_pass++;
    drain();
    drive(RW, 1'b0, 12'h343, 5'd1, 32'h00000066);
    tick();
    drive(RW, 1'b0, 12'h344, 5'd1, 32'h00000077);
    tick();
    idle();
    stall = 1'b1; flush = 1'b1;
    tick();
    stall = 1'b0; flush = 1'b0;
    n_total++; if (bus.ex_valid !== 1'b0 || bus.MEM_WB_CSR_write !== 1'b0)
      $display("FAIL fs_both got v=%b we=%b want v=0 we=0", bus.ex_valid, bus.MEM_WB_CSR_write); else n_pass++;
    tick();
    n_total++; if (bus.MEM_WB_CSR_write !== 1'b1 || bus.MEM_WB_CSR_addr !== 12'h343 || bus.WB_CSR_res !== 32'h00000066)
      $display("FAIL fs_held_write got we=%b a=%h d=%h want we=1 a=343 d=66", bus.MEM_WB_CSR_write, bus.MEM_WB_CSR_addr, bus.WB_CSR_res); else n_pass++;
    repeat (3) tick();
    n_total++; if (wr_a_q.size() !== 1) $display("FAIL fs_write_count got %0d want 1", wr_a_q.size()); else n_pass++;
    drain();
  endtask

  task automatic test_reset_mid();
    int bad;
    drive(RW, 1'b0, 12'h350, 5'd1, 32'h00000001);
    tick();
    drive(RW, 1'b0, 12'h351, 5'd1, 32'h00000002);
    tick();
    drive(RW, 1'b0, 12'h352, 5'd1, 32'h00000003);
    tick();
    idle();
    rst = 1'b1;
    tick();
    n_total++; if (bus.MEM_WB_CSR_write !== 1'b0 || bus.MEM_WB_CSR_addr !== 12'd0 || bus.WB_CSR_res !== 32'd0)
      $display("FAIL rmid_wport got we=%b a=%h d=%h want 0/000/0", bus.MEM_WB_CSR_write, bus.MEM_WB_CSR_addr, bus.WB_CSR_res); else n_pass++;
    n_total++; if (bus.ex_valid !== 1'b0 || bus.illegal !== 1'b0 || bus.csr_raddr !== 12'd0)
      $display("FAIL rmid_ex got v=%b ill=%b ra=%h want 0/0/000", bus.ex_valid, bus.illegal, bus.csr_raddr); else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if (bus.MEM_WB_CSR_write !== 1'b0) $display("FAIL rmid_after[%0d] got %b want 0", i, bus.MEM_WB_CSR_write); else n_pass++;
    end
    bad = 0;
    foreach (wr_a_q[i]) if (wr_a_q[i] === 12'h351 || wr_a_q[i] === 12'h352) bad++;
    n_total++; if (bad !== 0) $display("FAIL rmid_discard got %0d stale writes want 0", bad); else n_pass++;
    drain();
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_forwarding();
    test_suppression();
    test_readonly();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
